vga_dither_pipe: RTL and testbench

VGA_DITHER_PIPE -- requirements
Module: vga_dither_pipe

---
 rtl/vga_dither_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_vga_dither_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dither_pipe.sv
// vga_dither_pipe
//   VGA timing generator with a renderer-latency alignment pipeline and an
//   ordered (4x4 Bayer) dither that reduces IN_W-bit renderer colour to
//   OUT_W-bit DAC colour.
//
//   Optional build macro: VGA_TEMPORAL_DITHER_EN
//     defined   - the Bayer pattern is inverted on alternate frames
//                 (x/y LSBs XORed with the frame LSB that travels with the pixel)
//     undefined - static pattern; frame[0] has no effect on the outputs
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   enable              advances counters, pipeline and output register
//   px_x, px_y, px_vis  coordinate currently requested from the renderer
//   frame, frame_start  frame counter and (0,0) marker
//   r_in, g_in, b_in    renderer colour for the coordinate issued REND_LAT clocks ago
//   hsync, vsync, de    timing outputs, REND_LAT+1 clocks after the coordinate
//   r_out, g_out, b_out dithered colour, aligned with de
module vga_dither_pipe #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int IN_W     = 6,
    parameter int OUT_W    = 2,
    parameter int REND_LAT = 2,
    parameter int SYNC_POL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [10:0]      px_x,
    output logic [9:0]       px_y,
    output logic             px_vis,
    output logic [7:0]       frame,
    output logic             frame_start,
    input  logic [IN_W-1:0]  r_in,
    input  logic [IN_W-1:0]  g_in,
    input  logic [IN_W-1:0]  b_in,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [OUT_W-1:0] r_out,
    output logic [OUT_W-1:0] g_out,
    output logic [OUT_W-1:0] b_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int D       = IN_W - OUT_W;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);
    localparam logic [IN_W:0] SAT    = (IN_W + 1)'((1 << OUT_W) - 1);

    // Pipeline word: {f, y[1:0], x[1:0], vis, vsync, hsync}; syncs are kept
    // active-high internally so a cleared stage reads as "inactive".
    localparam int PW = 8;

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [7:0]  frame_q, frame_d;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (enable) begin
            if (x_q == H_LAST) begin
                x_d = 11'd0;
                if (y_q == V_LAST) begin
                    y_d     = 10'd0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end
        end
    end

    logic       vis_now;
    logic       raw_f;
    logic [PW-1:0] raw_w;

    assign vis_now = (x_q < H_VIS) && (y_q < V_VIS);

`ifdef VGA_TEMPORAL_DITHER_EN
    assign raw_f = frame_q[0];
`else
    assign raw_f = 1'b0;
`endif

    always_comb begin
        raw_w = {raw_f, y_q[1:0], x_q[1:0], vis_now,
                 (y_q >= VS_BEG) && (y_q < VS_END),
                 (x_q >= HS_BEG) && (x_q < HS_END)};
    end

    assign px_x        = x_q;
    assign px_y        = y_q;
    assign px_vis      = vis_now;
    assign frame       = frame_q;
    // Gated with rst_n so the marker is low while reset holds the counters at (0,0).
    assign frame_start = rst_n && (x_q == 11'd0) && (y_q == 10'd0);

    // ------------------------------------------------------------------
    // Alignment pipeline: delays the coordinate-derived bits by REND_LAT
    // ------------------------------------------------------------------
    logic [PW-1:0] al_w;

    generate
        if (REND_LAT == 0) begin : g_no_lat
            assign al_w = raw_w;
        end else begin : g_lat
            logic [PW-1:0] pipe_q [REND_LAT];
            logic [PW-1:0] pipe_d [REND_LAT];

            always_comb begin
                for (int i = 0; i < REND_LAT; i++) pipe_d[i] = pipe_q[i];
                if (enable) begin
                    pipe_d[0] = raw_w;
                    for (int i = 1; i < REND_LAT; i++) pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < REND_LAT; i++) pipe_q[i] <= '0;
                end else begin
                    for (int i = 0; i < REND_LAT; i++) pipe_q[i] <= pipe_d[i];
                end
            end

            assign al_w = pipe_q[REND_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Dither
    // ------------------------------------------------------------------
    function automatic logic [3:0] bayer_lut(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
            4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
            4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
            4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
        endcase
        return v;
    endfunction

    // Threshold is the Bayer value scaled to one output LSB (2^D input codes).
    // With D == 0 the threshold truncates to 0 and the shift is a no-op, so
    // the colour passes through unchanged.
    function automatic logic [OUT_W-1:0] dither(input logic [IN_W-1:0] c, input logic [3:0] b);
        int unsigned  t;
        logic [IN_W:0] sum;
        logic [IN_W:0] lvl;
        t   = (32'(b) << D) >> 4;
        sum = {1'b0, c} + (IN_W + 1)'(t);
        lvl = sum >> D;
        if (lvl > SAT) return SAT[OUT_W-1:0];
        return lvl[OUT_W-1:0];
    endfunction

    logic [1:0] ax, ay;
    logic [3:0] thr;

    assign ax  = al_w[4:3] ^ {al_w[7], al_w[7]};
    assign ay  = al_w[6:5] ^ {al_w[7], al_w[7]};
    assign thr = bayer_lut(ax, ay);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [2:0][IN_W-1:0]  chan_in;
    logic [2:0][OUT_W-1:0] chan_d, chan_q;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;

    assign chan_in = {b_in, g_in, r_in};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan_d[gi] = !enable ? chan_q[gi] :
                                al_w[2] ? dither(chan_in[gi], thr) : '0;
        end
    endgenerate

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        if (enable) begin
            hsync_d = al_w[0] ? SYNC_ACT : ~SYNC_ACT;
            vsync_d = al_w[1] ? SYNC_ACT : ~SYNC_ACT;
            de_d    = al_w[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
            de_q    <= 1'b0;
            chan_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            chan_q  <= chan_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign r_out = chan_q[0];
    assign g_out = chan_q[1];
    assign b_out = chan_q[2];

endmodule

// File: tb/tb_vga_dither_pipe.sv
// Testbench for vga_dither_pipe with a reduced timing raster (24 x 12) so
// whole frames fit in a short run. A renderer model feeds colour back with
// REND_LAT delay; each issued coordinate pushes its expected output to a
// scoreboard queue, popped when the DUT's output register presents it.
module tb_vga_dither_pipe;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int IN_W = 6, OUT_W = 2, LAT = 3;
    localparam int D = IN_W - OUT_W;

`ifdef VGA_TEMPORAL_DITHER_EN
    localparam bit TEMPORAL = 1'b1;
`else
    localparam bit TEMPORAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, enable;
    logic [10:0] px_x;
    logic [9:0]  px_y;
    logic px_vis, frame_start, hsync, vsync, de;
    logic [7:0] frame;
    logic [IN_W-1:0] r_in, g_in, b_in;
    logic [OUT_W-1:0] r_out, g_out, b_out;

    vga_dither_pipe #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .IN_W(IN_W), .OUT_W(OUT_W), .REND_LAT(LAT), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .px_x(px_x), .px_y(px_y), .px_vis(px_vis),
        .frame(frame), .frame_start(frame_start),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync(hsync), .vsync(vsync), .de(de),
        .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    always #5 clk = ~clk;

    typedef struct { int r; int g; int b; } col_t;
    typedef struct { int x; int y; logic hs; logic vs; logic de; int r; int g; int b; } exp_t;

    col_t rq[$];
    exp_t sb[$];
    exp_t exp_cur;
    int   mx, my, mf, mode;
    int   checks, errors;
    int   bayer [4][4];

    function automatic int dith(int c, int x, int y, int f);
        int ax, ay, t, v;
        ax = x & 3;
        ay = y & 3;
        if (TEMPORAL && (f & 1) == 1) begin
            ax = ax ^ 3;
            ay = ay ^ 3;
        end
        t = bayer[ax][ay] * (1 << D) / 16;
        v = (c + t) >> D;
        if (v > (1 << OUT_W) - 1) v = (1 << OUT_W) - 1;
        return v;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e.x = -1; e.y = -1; e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0;
        e.r = 0; e.g = 0; e.b = 0;
        return e;
    endfunction

    function automatic exp_t mk_exp(int x, int y, int f, col_t c);
        exp_t e;
        logic vis;
        vis  = (x < HA) && (y < VA);
        e.x  = x;
        e.y  = y;
        e.hs = (x >= HA + HF && x < HA + HF + HS) ? 1'b0 : 1'b1;
        e.vs = (y >= VA + VF && y < VA + VF + VS) ? 1'b0 : 1'b1;
        e.de = vis;
        e.r  = vis ? dith(c.r, x, y, f) : 0;
        e.g  = vis ? dith(c.g, x, y, f) : 0;
        e.b  = vis ? dith(c.b, x, y, f) : 0;
        return e;
    endfunction

    task automatic clear_model();
        rq.delete();
        sb.delete();
        mx = 0; my = 0; mf = 0;
        exp_cur = rst_exp();
        r_in = '0; g_in = '0; b_in = '0;
    endtask

    // One pixel clock: drive renderer, push/pop the scoreboard, compare.
    task automatic tick(input logic en);
        col_t c, d;
        exp_t nxt;
        logic e_vis, e_fs;
        nxt = rst_exp();
        enable = en;
        if (en) begin
            case (mode)
                0: begin c.r = 8;  c.g = 8;  c.b = 8;  end
                1: begin c.r = 63; c.g = 63; c.b = 63; end
                2: begin c.r = (mx == 5 && my == 5) ? 63 : 0; c.g = 0; c.b = 0; end
                default: begin
                    c.r = int'($urandom_range(0, 63));
                    c.g = int'($urandom_range(0, 63));
                    c.b = int'($urandom_range(0, 63));
                end
            endcase
            rq.push_back(c);
            if (rq.size() > LAT) begin
                d = rq.pop_front();
                r_in = IN_W'(d.r); g_in = IN_W'(d.g); b_in = IN_W'(d.b);
            end else begin
                r_in = '0; g_in = '0; b_in = '0;
            end
            sb.push_back(mk_exp(mx, my, mf, c));
            if (sb.size() > LAT) nxt = sb.pop_front();
            if (mx == HT - 1) begin
                mx = 0;
                if (my == VT - 1) begin
                    my = 0;
                    mf = (mf + 1) % 256;
                end else begin
                    my = my + 1;
                end
            end else begin
                mx = mx + 1;
            end
        end
        @(posedge clk);
        #1;
        if (en) exp_cur = nxt;
        checks++;
        if (hsync !== exp_cur.hs || vsync !== exp_cur.vs || de !== exp_cur.de ||
            r_out !== OUT_W'(exp_cur.r) || g_out !== OUT_W'(exp_cur.g) || b_out !== OUT_W'(exp_cur.b)) begin
            errors++;
            $display("FAIL sb_out pix=(%0d,%0d) got hs=%b vs=%b de=%b rgb=%0d/%0d/%0d want hs=%b vs=%b de=%b rgb=%0d/%0d/%0d",
                     exp_cur.x, exp_cur.y, hsync, vsync, de, r_out, g_out, b_out,
                     exp_cur.hs, exp_cur.vs, exp_cur.de, exp_cur.r, exp_cur.g, exp_cur.b);
        end
        e_vis = (mx < HA) && (my < VA);
        e_fs  = (mx == 0) && (my == 0);
        checks++;
        if (px_x !== 11'(mx) || px_y !== 10'(my) || frame !== 8'(mf) ||
            px_vis !== e_vis || frame_start !== e_fs) begin
            errors++;
            $display("FAIL coord got x=%0d y=%0d f=%0d vis=%b fs=%b want x=%0d y=%0d f=%0d vis=%b fs=%b",
                     px_x, px_y, frame, px_vis, frame_start, mx, my, mf, e_vis, e_fs);
        end
    endtask

    task automatic goto_xy(input int x, input int y);
        int n;
        n = 0;
        while (!(mx == x && my == y) && n < HT * VT + 10) begin
            tick(1'b1);
            n++;
        end
        checks++;
        if (!(mx == x && my == y)) begin
            errors++;
            $display("FAIL goto_xy got (%0d,%0d) want (%0d,%0d)", mx, my, x, y);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        mode = 3;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got hs=%b vs=%b de=%b fs=%b want 1 1 0 0", hsync, vsync, de, frame_start);
        end
        checks++;
        if (r_out !== '0 || g_out !== '0 || b_out !== '0) begin
            errors++;
            $display("FAIL reset_rgb got %0d/%0d/%0d want 0/0/0", r_out, g_out, b_out);
        end
        checks++;
        if (px_x !== 11'd0 || px_y !== 10'd0 || frame !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt got x=%0d y=%0d f=%0d want 0 0 0", px_x, px_y, frame);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (frame_start !== 1'b1 || px_x !== 11'd0 || px_y !== 10'd0) begin
            errors++;
            $display("FAIL release_fs got fs=%b x=%0d y=%0d want 1 0 0", frame_start, px_x, px_y);
        end
    endtask

    task automatic test_full_frame();
        int fs_n, hl, hf, vl;
        logic prev;
        fs_n = 0; hl = 0; hf = 0; vl = 0;
        mode = 3;
        repeat (LAT + 1) tick(1'b1);
        prev = hsync;
        repeat (HT * VT) begin
            tick(1'b1);
            if (frame_start === 1'b1) fs_n++;
            if (hsync === 1'b0) hl++;
            if (prev === 1'b1 && hsync === 1'b0) hf++;
            if (vsync === 1'b0) vl++;
            prev = hsync;
        end
        checks++;
        if (fs_n != 1) begin errors++; $display("FAIL frame_start_count got %0d want 1", fs_n); end
        checks++;
        if (hl != HS * VT) begin errors++; $display("FAIL hsync_low got %0d want %0d", hl, HS * VT); end
        checks++;
        if (hf != VT) begin errors++; $display("FAIL hsync_pulses got %0d want %0d", hf, VT); end
        checks++;
        if (vl != VS * HT) begin errors++; $display("FAIL vsync_low got %0d want %0d", vl, VS * HT); end
        checks++;
        if (frame !== 8'd1) begin errors++; $display("FAIL frame_inc got %0d want 1", frame); end
    endtask

    task automatic test_dither_tile();
        int z, o, bad, den;
        z = 0; o = 0; bad = 0; den = 0;
        mode = 0;
        goto_xy(0, 0);
        repeat (HT * VT + LAT) begin
            tick(1'b1);
            if (exp_cur.de && exp_cur.x < 4 && exp_cur.y < 4) begin
                if (r_out === 2'd0) z++;
                else if (r_out === 2'd1) o++;
            end
        end
        checks++;
        if (z != 8 || o != 8) begin
            errors++;
            $display("FAIL tile_c8 got zeros=%0d ones=%0d want 8 8", z, o);
        end
        mode = 1;
        goto_xy(0, 0);
        repeat (HT * VT + LAT) begin
            tick(1'b1);
            if (de === 1'b1) begin
                den++;
                if (r_out !== 2'd3 || g_out !== 2'd3 || b_out !== 2'd3) bad++;
            end
        end
        checks++;
        if (bad != 0 || den != HA * VA) begin
            errors++;
            $display("FAIL sat_c63 got non3=%0d de_cycles=%0d want 0 %0d", bad, den, HA * VA);
        end
    endtask

    task automatic test_single_pixel();
        mode = 2;
        goto_xy(0, 0);
        goto_xy(5, 5);
        repeat (LAT) tick(1'b1);
        checks++;
        if (r_out !== 2'd0 || de !== 1'b1) begin
            errors++; $display("FAIL px_before got r=%0d de=%b want 0 1", r_out, de);
        end
        tick(1'b1);
        checks++;
        if (r_out !== 2'd3 || de !== 1'b1 || g_out !== 2'd0 || b_out !== 2'd0) begin
            errors++; $display("FAIL px_hit got r=%0d g=%0d b=%0d de=%b want 3 0 0 1", r_out, g_out, b_out, de);
        end
        tick(1'b1);
        checks++;
        if (r_out !== 2'd0) begin
            errors++; $display("FAIL px_after got r=%0d want 0", r_out);
        end
    endtask

    task automatic test_enable_hold();
        mode = 3;
        goto_xy(10, 3);
        repeat (10) tick(1'b0);
        checks++;
        if (px_x !== 11'd10 || px_y !== 10'd3) begin
            errors++; $display("FAIL hold_xy got (%0d,%0d) want (10,3)", px_x, px_y);
        end
        repeat (40) tick(1'b1);
    endtask

    task automatic test_back_to_back();
        int f0;
        mode = 3;
        f0 = mf;
        repeat (2 * HT * VT) tick(1'b1);
        checks++;
        if (frame !== 8'(f0 + 2)) begin
            errors++; $display("FAIL b2b_frame got %0d want %0d", frame, f0 + 2);
        end
    endtask

    task automatic test_async_reset();
        mode = 3;
        goto_xy(7, 5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0 || frame_start !== 1'b0 ||
            r_out !== '0 || g_out !== '0 || b_out !== '0) begin
            errors++;
            $display("FAIL async_out got hs=%b vs=%b de=%b fs=%b rgb=%0d/%0d/%0d want 1 1 0 0 0/0/0",
                     hsync, vsync, de, frame_start, r_out, g_out, b_out);
        end
        checks++;
        if (px_x !== 11'd0 || px_y !== 10'd0 || frame !== 8'd0) begin
            errors++; $display("FAIL async_cnt got x=%0d y=%0d f=%0d want 0 0 0", px_x, px_y, frame);
        end
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (px_x !== 11'd0 || frame !== 8'd0 || de !== 1'b0) begin
            errors++; $display("FAIL reset_hold got x=%0d f=%0d de=%b want 0 0 0", px_x, frame, de);
        end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (HT * VT / 2) tick(1'b1);
        checks++;
        if (frame !== 8'd0) begin
            errors++; $display("FAIL restart_frame got %0d want 0", frame);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        bayer = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
        rst_n = 1'b0;
        enable = 1'b0;
        mode = 3;
        clear_model();
        test_reset();
        test_full_frame();
        test_dither_tile();
        test_single_pixel();
        test_enable_hold();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
